// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the MIPS32 instruction fetch stage.
// Holds the fetch FSM encoding and a PC alignment helper.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] IFU_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] IFU_HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
  localparam int          INST_MEM_SIZE = 1024;

  localparam logic [0:0] S_FETCH  = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: instruction word, PC+4 and valid bit.
// Flush inserts a NOP bubble and beats hold; hold beats load.
module instruction_fetch_unit_if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Capture the fetched word, insert a bubble, or keep the current entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= IFU_NOP_WORD;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= IFU_NOP_WORD;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_load && !i_hold) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, combinational imem address, halt FSM and fetch counter.
// Redirects realign the target and latch a sticky misalign flag.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter logic [31:0] HALT_WORD = IFU_HALT_WORD,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_target_i,
  output logic [31:0]        imem_addr_o,
  input  logic [31:0]        imem_instr_i,
  output logic [31:0]        ifid_instr_o,
  output logic [31:0]        ifid_pc4_o,
  output logic               ifid_valid_o,
  output logic               halted_o,
  output logic               misalign_o,
  output logic [COUNT_W-1:0] fetch_count_o
);

  logic [31:0]        r_pc;
  logic [0:0]         r_state;
  logic               r_misalign;
  logic [COUNT_W-1:0] r_count;

  logic        w_halted;
  logic        w_is_halt;
  logic        w_fetch;
  logic        w_flush;
  logic        w_hold;
  logic [31:0] w_pc4;

  assign w_halted  = (r_state == S_HALTED);
  assign w_is_halt = (imem_instr_i == HALT_WORD);
  assign w_fetch   = !w_halted && !redirect_i && !stall_i;
  assign w_pc4     = r_pc + 32'd4;
  assign w_flush   = redirect_i || (w_halted && !stall_i);
  assign w_hold    = stall_i && !redirect_i;

  // PC: load aligned target on redirect, advance on a non-halt fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= align_word(redirect_target_i);
    end else if (w_fetch && !w_is_halt) begin
      r_pc <= w_pc4;
    end
  end

  // Fetch FSM: halt word parks fetch until the next redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else if (redirect_i) begin
      r_state <= S_FETCH;
    end else if (w_fetch && w_is_halt) begin
      r_state <= S_HALTED;
    end
  end

  // Sticky flag for redirect targets that are not word aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_i && (redirect_target_i[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  // Count every valid instruction written into IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_fetch) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  instruction_fetch_unit_if_id_register u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fetch),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_instr (imem_instr_i),
    .i_pc4   (w_pc4),
    .o_instr (ifid_instr_o),
    .o_pc4   (ifid_pc4_o),
    .o_valid (ifid_valid_o)
  );

  assign imem_addr_o   = r_pc;
  assign halted_o      = w_halted;
  assign misalign_o    = r_misalign;
  assign fetch_count_o = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit.
// Driver pushes model expectations; monitor pops after each edge.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] ADD  = 32'h0211_4020;
  localparam logic [31:0] ADDU = 32'h0113_4821;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = 32'h0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  logic [31:0] mem [INST_MEM_SIZE];
  assign imem_instr_i = mem[imem_addr_o[11:2]];

  instruction_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_addr_o       (imem_addr_o),
    .imem_instr_i      (imem_instr_i),
    .ifid_instr_o      (ifid_instr_o),
    .ifid_pc4_o        (ifid_pc4_o),
    .ifid_valid_o      (ifid_valid_o),
    .halted_o          (halted_o),
    .misalign_o        (misalign_o),
    .fetch_count_o     (fetch_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  exp_t exp_q[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halt, m_mis;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock edge of fetch behaviour, straight from the stage rules
  task automatic model_edge(input bit st, input bit rd,
                            input logic [31:0] tgt);
    logic [31:0] w;
    w = mem[m_pc[11:2]];
    if (rd) begin
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc = tgt - (tgt % 4);
      m_halt = 1'b0;
      bubble();
    end else if (m_halt) begin
      if (!st) bubble();
    end else if (!st) begin
      m_instr = w;
      m_pc4 = m_pc + 4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 1;
      if (w == HALT) m_halt = 1'b1;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic apply(input bit st, input bit rd, input logic [31:0] tgt);
    exp_t e;
    stall_i = st;
    redirect_i = rd;
    redirect_target_i = tgt;
    model_edge(st, rd, tgt);
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.halted = m_halt; e.mis = m_mis; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    @(negedge clk);
    apply(st, rd, tgt);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(1'b0, 1'b0, 32'h0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_addr"}, imem_addr_o, 32'h0);
    check({tag, "_instr"}, ifid_instr_o, 32'h0);
    check({tag, "_pc4"}, ifid_pc4_o, 32'h0);
    check({tag, "_valid"}, {31'h0, ifid_valid_o}, 32'h0);
    check({tag, "_halted"}, {31'h0, halted_o}, 32'h0);
    check({tag, "_mis"}, {31'h0, misalign_o}, 32'h0);
    check({tag, "_cnt"}, fetch_count_o, 32'h0);
  endtask

  // Monitor: compare every DUT output against the next expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_addr", imem_addr_o, e.addr);
        check("sb_instr", ifid_instr_o, e.instr);
        check("sb_pc4", ifid_pc4_o, e.pc4);
        check("sb_valid", {31'h0, ifid_valid_o}, {31'h0, e.valid});
        check("sb_halted", {31'h0, halted_o}, {31'h0, e.halted});
        check("sb_mis", {31'h0, misalign_o}, {31'h0, e.mis});
        check("sb_cnt", fetch_count_o, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < INST_MEM_SIZE; i++) begin
      v = $urandom;
      if (v == HALT) v = v ^ 32'h1;
      mem[i] = v;
    end
    mem[0] = ADD;
    mem[1] = ADDU;
    mem[2] = 32'h0;
    mem[3] = 32'h2008_0005;
    model_reset();

    #3;
    reset_check("rst0");

    release_rst();
    #1;
    check("addr0", imem_addr_o, 32'h0);
    after_edge();
    check("e1_instr", ifid_instr_o, ADD);
    check("e1_addr", imem_addr_o, 32'h4);
    step(0, 0, 0);
    after_edge();
    check("e2_instr", ifid_instr_o, ADDU);
    check("e2_pc4", ifid_pc4_o, 32'h8);
    check("e2_cnt", fetch_count_o, 32'd2);

    step(1, 0, 0);
    step(1, 0, 0);
    after_edge();
    check("stall_addr", imem_addr_o, 32'h8);
    check("stall_instr", ifid_instr_o, ADDU);
    check("stall_cnt", fetch_count_o, 32'd2);
    step(0, 0, 0);
    after_edge();
    check("nop_pc4", ifid_pc4_o, 32'd12);
    check("nop_valid", {31'h0, ifid_valid_o}, 32'h1);
    step(0, 0, 0);

    step(1, 1, 32'h40);
    after_edge();
    check("rdst_addr", imem_addr_o, 32'h40);
    check("rdst_valid", {31'h0, ifid_valid_o}, 32'h0);
    check("rdst_cnt", fetch_count_o, 32'd4);

    step(0, 1, 32'h22);
    after_edge();
    check("mis_addr", imem_addr_o, 32'h20);
    check("mis_flag", {31'h0, misalign_o}, 32'h1);
    repeat (3) step(0, 0, 0);
    after_edge();
    check("mis_sticky", {31'h0, misalign_o}, 32'h1);

    mem[3] = HALT;
    step(0, 1, 32'h0);
    repeat (4) step(0, 0, 0);
    after_edge();
    check("halt_instr", ifid_instr_o, HALT);
    check("halt_flag", {31'h0, halted_o}, 32'h1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    after_edge();
    check("halt_addr", imem_addr_o, 32'hC);
    check("halt_bubble", {31'h0, ifid_valid_o}, 32'h0);
    step(0, 1, 32'h0);
    step(0, 0, 0);
    after_edge();
    check("restart_instr", ifid_instr_o, ADD);

    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    after_edge();
    check("wrap_pc4", ifid_pc4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);

    step(0, 1, 32'h14);
    after_edge();
    check("pre_rst_addr", imem_addr_o, 32'h14);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    reset_check("async");
    model_reset();

    for (int i = 0; i < INST_MEM_SIZE; i++) begin
      v = $urandom;
      if ($urandom_range(0, 7) == 0) v = HALT;
      else if (v == HALT) v = v ^ 32'h1;
      mem[i] = v;
    end
    release_rst();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] t;
      bit st, rd;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h3FFF);
      step(st, rd, t);
    end

    repeat (3) @(posedge clk);
    #2;
    check("drain", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory interface and the IF stage of the 5-stage MIPS32 pipeline.
- Holds the PC, drives the word address to the combinational-read instruction memory, and captures the returned word into the IF/ID pipeline register.
- Obeys stall requests from the hazard unit and redirect/flush requests from branch/jump resolution.
- Stops fetching on a HALT word until redirected.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_WORD, 32'hFC000000 (opcode 6'h3F, unused by the ISA), fetched word that halts fetch.
- COUNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard unit stall (load-use); hold PC and IF/ID.
- redirect_i  in  1  branch taken or jump resolved; flush IF/ID and load PC from target.
- redirect_target_i  in  32  new PC on redirect.
- imem_addr_o  out  32  byte address to instruction memory; equals PC, combinational.
- imem_instr_i  in  32  instruction word returned in the same cycle (combinational read).
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4 of that instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction (0 = bubble, instr = NOP 0x00000000).
- halted_o  out  1  fetch is in HALTED state.
- misalign_o  out  1  sticky; set when a redirect target has bits [1:0] != 0.
- fetch_count_o  out  COUNT_W  number of valid instructions latched into IF/ID.

Behaviour:
Reset (async, immediate):
- PC=RESET_PC; ifid_instr_o=0; ifid_pc4_o=0; ifid_valid_o=0; halted_o=0; misalign_o=0; fetch_count_o=0; state=FETCH.

Address path:
- imem_addr_o=PC with no register, so the instruction is available in the same cycle.
- Latency from PC to IF/ID is one clock edge.

State FETCH, evaluated per rising edge in this priority order:
1. redirect_i=1: PC<=target with bits[1:0] forced to 00. IF/ID<=NOP with valid=0. If target[1:0]!=0, misalign_o<=1. Redirect overrides a simultaneous stall.
2. stall_i=1: PC, IF/ID and count hold unchanged.
3. imem_instr_i==HALT_WORD: IF/ID<={HALT_WORD, PC+4, valid=1}; count+1; PC holds; state<=HALTED.
4. Otherwise: IF/ID<={imem_instr_i, PC+4, valid=1}; PC<=PC+4; count+1.

State HALTED:
- halted_o=1.
- Without a stall, IF/ID<=NOP with valid=0; with stall_i=1, IF/ID holds.
- PC holds; count holds.
- redirect_i=1: PC<=target, IF/ID<=bubble, state<=FETCH.

Arithmetic and boundaries:
- PC+4 wraps modulo 2^32. The memory decodes only addr[11:2], so aliasing above 4 KB is the memory's concern, not this block's.
- fetch_count_o wraps modulo 2^COUNT_W.
- The all-zero word is a legal NOP (sll $0,$0,0) and is latched as valid.
- misalign_o clears only on rst.
- rst asserted mid-stall or mid-redirect wins unconditionally.

Decomposition:
- mips_defines.vh holds the shared constants: `NOP_WORD (32'h0), `HALT_WORD, `RESET_PC, and the existing `INST_MEM_SIZE.
- Single natural sub-module if_id_register: holds instr, pc4 and valid; inputs for load, hold (stall) and flush (bubble); async active-high rst.
- The PC, FSM and counter stay in the top level.

Test Plan:
- Sequential fetch: memory loaded with ADD 0x02114020 at word 0 and ADDU 0x01134821 at word 1; release rst.
  - imem_addr_o=0, then 4.
  - After edge 1, ifid_instr_o=0x02114020, pc4=4, valid=1.
  - After edge 2, ifid_instr_o=0x01134821, pc4=8; fetch_count_o=2.
- Stall: assert stall_i for 2 cycles at PC=8.
  - imem_addr_o stays 8.
  - IF/ID keeps 0x01134821/pc4=8.
  - Count stays 2.
  - On release, fetch resumes with pc4=12.
- Redirect vs stall: at PC=0x10, assert redirect_i=1, stall_i=1, target=0x40.
  - Next PC=0x40; ifid_valid_o=0, instr=0; count unchanged.
- Misaligned redirect: target 0x22.
  - PC=0x20; misalign_o=1.
  - misalign_o stays 1 after further normal fetches.
- Halt: word 3 = 0xFC000000.
  - IF/ID gets 0xFC000000 with valid=1, and halted_o=1.
  - Following cycles show valid=0 with PC=0xC held.
  - A redirect to 0 restarts fetch at the ADD word.
- Async reset mid-run: assert rst between clock edges at PC=0x14.
  - All outputs return to reset values immediately, without waiting for a clock edge.
